// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the main-bus arbiter
// Contents:
//   arb_state_e      FSM state encoding (IDLE, GRANT, OWN, RELEASE)
//   BUS_REQ_*        4-bit bus request codes; BUS_REQ_IDLE means "not requesting"
//   DEFAULT_NREQ     default number of requesters
//   DEFAULT_TIMEOUT  default OWN watchdog limit (used with ARB_TIMEOUT_EN)
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    OWN     = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  localparam logic [3:0] BUS_REQ_IDLE = 4'b0000;
  localparam logic [3:0] BUS_REQ_RECV = 4'b0001;
  localparam logic [3:0] BUS_REQ_OPND = 4'b0011;

  localparam int DEFAULT_NREQ    = 4;
  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant bundle between engines and the bus arbiter
// Parameter: NREQ number of requesters (2..8)
// Signals:
//   req_code    [4*NREQ]       per-requester request code, slice i = [4i+3:4i]
//   done_in     [NREQ]         per-requester completion level
//   grant       [NREQ]         one-hot grant, zero when no owner
//   oe_n                       active-low output enable to the owner
//   owner_id    [$clog2(NREQ)] current or last owner index
//   owner_code  [4]            owner's request code latched at grant
//   busy                       high in GRANT, OWN and RELEASE
//   timeout_err                one-cycle pulse on watchdog release
// Modports: master = arbiter side, slave = engine side
interface bus_arbiter_if #(
  parameter int NREQ = 4
);
  localparam int IW = $clog2(NREQ);

  logic [4*NREQ-1:0] req_code;
  logic [NREQ-1:0]   done_in;
  logic [NREQ-1:0]   grant;
  logic              oe_n;
  logic [IW-1:0]     owner_id;
  logic [3:0]        owner_code;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  req_code, done_in,
    output grant, oe_n, owner_id, owner_code, busy, timeout_err
  );

  modport slave (
    output req_code, done_in,
    input  grant, oe_n, owner_id, owner_code, busy, timeout_err
  );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotate-priority selector
// Parameter: NREQ number of requesters
// Ports:
//   req   in  [NREQ]  requesting vector
//   last  in  [IW]    index granted most recently; scan starts at last+1
//   valid out         at least one requester is requesting
//   idx   out [IW]    first requesting index after last, modulo NREQ
module rr_picker #(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan from the farthest offset down to the nearest so that the
  // closest requester after last is the final (winning) assignment.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(last) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin arbiter and sequencer for the shared 4-bit main bus
// Parameters: NREQ (2..8) requesters; TIMEOUT (2..255) OWN watchdog limit
// Optional feature: define ARB_TIMEOUT_EN to enable the OWN watchdog; otherwise
//   timeout_err is tied low and OWN is held until done or request withdrawal.
// Ports:
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset
//   bus    bus_arbiter_if.master (req_code, done_in in; grant, oe_n, owner_id,
//          owner_code, busy, timeout_err out)
module bus_arbiter
  import arb_pkg::*;
#(
  parameter int NREQ    = DEFAULT_NREQ,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.master bus
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("bus_arbiter: NREQ out of range");
  end
  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT out of range");
  end

  arb_state_e      state_q, state_d;
  logic [IW-1:0]   owner_id_q;
  logic [3:0]      owner_code_q;
  logic [IW-1:0]   last_q;
  logic            timeout_q;

  logic [NREQ-1:0] req_vec;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic [3:0]      owner_req;
  logic            release_cond;
  logic            wdog_expire;

  always_comb begin
    req_vec = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_vec[i] = (bus.req_code[4*i +: 4] != BUS_REQ_IDLE);
    end
  end

  rr_picker #(.NREQ(NREQ)) u_picker (
    .req   (req_vec),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Only the owner's own done/withdrawal can end ownership.
  assign owner_req    = bus.req_code[4*int'(owner_id_q) +: 4];
  assign release_cond = bus.done_in[owner_id_q] || (owner_req == BUS_REQ_IDLE);

`ifdef ARB_TIMEOUT_EN
  logic [7:0] wdog_q;

  // Cleared while in GRANT so it reads 0 in the first OWN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
    end else if (state_q == GRANT) begin
      wdog_q <= '0;
    end else if (state_q == OWN) begin
      wdog_q <= wdog_q + 8'd1;
    end
  end

  assign wdog_expire = (wdog_q == 8'(TIMEOUT - 1));
`else
  assign wdog_expire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_valid) state_d = GRANT;
      GRANT:   state_d = OWN;
      OWN:     if (release_cond || wdog_expire) state_d = RELEASE;
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Owner latches, round-robin pointer and timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_id_q   <= '0;
      owner_code_q <= '0;
      last_q       <= IW'(NREQ - 1);
      timeout_q    <= 1'b0;
    end else begin
      if (state_q == IDLE && pick_valid) begin
        owner_id_q   <= pick_idx;
        owner_code_q <= bus.req_code[4*int'(pick_idx) +: 4];
        last_q       <= pick_idx;
      end
      // A normal release in the same cycle wins, so no error is flagged then.
      timeout_q <= (state_q == OWN) && !release_cond && wdog_expire;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    bus.grant = '0;
    bus.oe_n  = 1'b1;
    bus.busy  = (state_q != IDLE);
    if (state_q == GRANT || state_q == OWN) begin
      bus.grant[owner_id_q] = 1'b1;
    end
    if (state_q == OWN) begin
      bus.oe_n = 1'b0;
    end
  end

  assign bus.owner_id    = owner_id_q;
  assign bus.owner_code  = owner_code_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter and sequencer for the shared 4-bit main bus. Up to NREQ ALU/IO engines each present a 4-bit bus request code. The arbiter grants exactly one owner at a time and drives that owner's active-low output enable. It then holds the grant until the owner signals completion or withdraws its request. It sits between the engine instances and the register-file/IO responder, which consumes the latched owner code.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- TIMEOUT, 16: maximum cycles in OWN before a forced release. Used only with ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; **asynchronous, active-low**.
- req_code  in  4*NREQ  per-requester bus request code; slice i is [4i+3:4i]; 4'b0000 means idle.
- done_in  in  NREQ  per-requester completion; registered level, sampled at posedge.
- grant  out  NREQ  one-hot grant; all zero when no owner.
- oe_n  out  1  active-low output enable to the current owner; low only in OWN.
- owner_id  out  $clog2(NREQ)  index of the current or last owner.
- owner_code  out  4  req_code of the owner, latched at grant.
- busy  out  1  high in GRANT, OWN and RELEASE.
- timeout_err  out  1  one-cycle pulse on forced release.

## Operation
- **Reset values:**
  - grant=0, oe_n=1, owner_id=0, owner_code=0, busy=0, timeout_err=0.
  - State=IDLE, round-robin pointer last=NREQ-1, so requester 0 wins first.
- **Requesting:** requester i is requesting when its req_code slice is not 4'b0000.
- **IDLE:**
  - If no requester is requesting, stay in IDLE.
  - Otherwise pick the first requesting index scanning last+1, last+2, … modulo NREQ.
  - Register grant[i]=1, owner_id=i, owner_code=req_code[i], last=i, busy=1. Go to GRANT.
- **GRANT:**
  - One cycle of bus-turnaround setup; oe_n stays 1.
  - Always go to OWN.
- **OWN:**
  - oe_n=0.
  - Go to RELEASE if done_in[owner] is 1, or if req_code[owner] is 4'b0000.
  - Changes to req_code[owner] other than going to zero are ignored; owner_code stays latched.
  - Requests from other requesters are ignored.
- **RELEASE:**
  - grant=0, oe_n=1, busy=1; owner_id and owner_code hold.
  - Always go to IDLE, with busy=0 there.
- **Fairness:** with all NREQ requesters continuously requesting, each is granted exactly once per NREQ grants.
- **done_in from non-owners:** ignored in every state.
- **done_in while not in OWN:** ignored. A done asserted in GRANT is not remembered.
- **Reset mid-operation:** all outputs and state return to reset values immediately (asynchronous). The pointer also resets.

## Timing
- **Request to grant:** a request sampled at edge N in IDLE gives grant and busy visible after edge N+1. oe_n goes low after edge N+2.
- **Release:** done_in sampled at edge M in OWN gives grant=0 and oe_n=1 after edge M+1, and busy=0 after edge M+2.
- **Back-to-back turnaround:** the earliest next grant is after edge M+3. This gives a minimum of 2 idle-bus cycles between owners.
- **Outputs:** all are registered; there are no combinational paths from inputs to outputs.

## Configuration
- **ARB_TIMEOUT_EN defined:**
  - An 8-bit watchdog counter clears on entry to OWN and increments each OWN cycle.
  - If it reaches TIMEOUT-1 with no release condition, go to RELEASE and pulse timeout_err for 1 cycle, coincident with the RELEASE cycle. owner_id identifies the offender.
  - A normal release on the same cycle takes priority; in that case there is no timeout_err.
- **ARB_TIMEOUT_EN undefined:**
  - There is no counter.
  - timeout_err is tied to 0.
  - OWN is held indefinitely until done_in or request withdrawal.

## Structure
- **Shared package arb_pkg:**
  - State enum: IDLE, GRANT, OWN, RELEASE.
  - Request code constants: BUS_REQ_IDLE=4'b0000, BUS_REQ_RECV=4'b0001, BUS_REQ_OPND=4'b0011.
  - Default TIMEOUT constant.
- **Sub-module rr_picker:**
  - Combinational rotate-priority selector.
  - Inputs: request vector, last.
  - Outputs: valid, index.
- **bus_arbiter:** contains the FSM, latches and watchdog, and instantiates rr_picker.

## Test plan
- **Reset:** hold rst_n=0 with random inputs → grant=0, oe_n=1, busy=0, owner_code=0, timeout_err=0. Release reset with req 0 and req 1 both requesting → grant=4'b0001.
- **Single request:** req_code[1]=4'b0011 at edge 0 → grant=4'b0010 and owner_code=4'b0011 after edge 1, oe_n=0 after edge 2. done_in[1]=1 at edge 5 → grant=0 after edge 6, busy=0 after edge 7.
- **Round robin:** requesters 0, 2 and 3 continuously requesting, each asserting done 2 cycles into OWN → grant order 0, 2, 3, 0, 2. Gaps between owners are exactly 2 cycles with oe_n=1.
- **Withdrawal and noise:**
  - req_code[2] drops to 0 in OWN → RELEASE next cycle.
  - done_in[0] pulsed while 2 owns → no effect.
  - req_code[2] changes 0011→0001 in OWN → owner_code stays 0011.
- **Timeout (ARB_TIMEOUT_EN, TIMEOUT=8):**
  - Requester 2 never signals done → one timeout_err pulse after its 8th OWN cycle, with owner_id=2. The next grant goes to requester 3 if it is requesting.
  - Without the macro → grant is still held at cycle 100.
- **Reset mid-OWN:**
  - rst_n pulsed low while requester 3 owns → outputs return to reset values within the same cycle.
  - After release of reset, with requesters 3 and 0 requesting → grant goes to requester 0.
